serial_ripple_subtractor: RTL



---
 rtl/serial_ripple_subtractor.sv | 108 ++++++++++
 1 files changed

// File: rtl/serial_ripple_subtractor.sv
// Bit-serial ripple-borrow subtractor: diff = a - b - bin, one bit per clock, LSB first.
// Optional signed-overflow output ovf is built when SUB_OVF_EN is defined.
module serial_ripple_subtractor #(
   parameter int N = 4
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic         bin,
   output logic         busy,
   output logic         done,
   output logic [N-1:0] diff,
   output logic         bout
`ifdef SUB_OVF_EN
   ,output logic        ovf
`endif
);

   localparam int CW = $clog2(N);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_RUN  = 2'd1;
   localparam logic [1:0] S_DONE = 2'd2;

   logic [1:0]    r_state;
   logic [N-1:0]  r_a;
   logic [N-1:0]  r_b;
   logic          r_brw;
   logic [CW-1:0] r_cnt;
   logic [N-1:0]  r_res;
   logic [N-1:0]  r_diff;
   logic          r_bout;

   logic          w_accept;
   logic          w_last;
   logic          w_d;
   logic          w_brw_next;
   logic [N-1:0]  w_res_next;

   // Single full-subtractor cell operating on the current LSBs.
   assign w_d        = r_a[0] ^ r_b[0] ^ r_brw;
   assign w_brw_next = (~r_a[0] & r_b[0]) | (~(r_a[0] ^ r_b[0]) & r_brw);
   assign w_res_next = {w_d, r_res[N-1:1]};
   assign w_last     = (r_cnt == CW'(N - 1));
   assign w_accept   = start && ((r_state == S_IDLE) || (r_state == S_DONE));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_a     <= '0;
         r_b     <= '0;
         r_brw   <= 1'b0;
         r_cnt   <= '0;
         r_res   <= '0;
         r_diff  <= '0;
         r_bout  <= 1'b0;
      end else if (w_accept) begin
         r_a     <= a;
         r_b     <= b;
         r_brw   <= bin;
         r_cnt   <= '0;
         r_state <= S_RUN;
      end else if (r_state == S_RUN) begin
         r_a   <= r_a >> 1;
         r_b   <= r_b >> 1;
         r_brw <= w_brw_next;
         r_res <= w_res_next;
         r_cnt <= r_cnt + CW'(1);
         if (w_last) begin
            r_diff  <= w_res_next;
            r_bout  <= w_brw_next;
            r_state <= S_DONE;
         end
      end else begin
         r_state <= S_IDLE;
      end
   end

`ifdef SUB_OVF_EN
   logic r_amsb;
   logic r_bmsb;
   logic r_ovf;

   // Operand MSBs are kept aside because the shift registers lose them during RUN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_amsb <= 1'b0;
         r_bmsb <= 1'b0;
         r_ovf  <= 1'b0;
      end else if (w_accept) begin
         r_amsb <= a[N-1];
         r_bmsb <= b[N-1];
      end else if ((r_state == S_RUN) && w_last) begin
         r_ovf <= (r_amsb != r_bmsb) && (w_res_next[N-1] != r_amsb);
      end
   end

   assign ovf = r_ovf;
`endif

   assign busy = (r_state == S_RUN);
   assign done = (r_state == S_DONE);
   assign diff = r_diff;
   assign bout = r_bout;

endmodule
